// File: rtl/fft_pkg.sv
// Shared definitions for the fft block and its frame-side helpers:
// transform size, sample type, unloader state encoding and index bit-reversal.
package fft_pkg;

   localparam int FFT_POINTS = 1024;
   localparam int FFT_LOG2   = $clog2(FFT_POINTS);

   typedef logic [31:0] sample_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } unl_state_t;

   // Reverse the low nbits bits of idx; bits at or above nbits come back as 0.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < nbits) r[b] = idx[nbits-1-b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Purely combinational N-bit index reverser (bit 0 <-> bit N-1).
module fft_bitrev #(
   parameter int N = 10
) (
   input  logic [N-1:0] i_idx,
   output logic [N-1:0] o_idx
);

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_bit
         assign o_idx[g] = i_idx[N-1-g];
      end
   endgenerate

endmodule

// File: rtl/fft_frame_unloader.sv
// Snapshots a complete fft result frame on the rising edge of the fft done
// level and streams it out one word per valid/ready handshake, in natural or
// bit-reversed bin order. Frames arriving while one is still streaming are
// dropped and flagged, except when they coincide with the final accept.
module fft_frame_unloader
   import fft_pkg::*;
#(
   parameter  int POINTS = FFT_POINTS,
   parameter  int DW     = 32,
   parameter  bit BITREV = 1'b0,
   localparam int LG     = $clog2(POINTS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] frame_in [POINTS],
   input  logic          frame_done,
   output logic [DW-1:0] m_data,
   output logic [LG-1:0] m_index,
   output logic          m_valid,
   output logic          m_last,
   input  logic          m_ready,
   output logic          busy,
   output logic          overrun
);

   localparam logic [LG-1:0] LAST_BEAT = LG'(POINTS - 1);

   unl_state_t    r_state;
   unl_state_t    w_state_nxt;
   logic [LG-1:0] r_cnt;
   logic [LG-1:0] w_cnt_nxt;
   logic [LG-1:0] w_ord;
   logic          r_done_q;
   logic [DW-1:0] r_buf [POINTS];

   logic          w_new_frame;
   logic          w_stream;
   logic          w_final;
   logic          w_accept;
   logic          w_capture;

   assign w_new_frame = frame_done & ~r_done_q;
   assign w_stream    = (r_state == ST_STREAM);
   assign w_final     = w_stream && (r_cnt == LAST_BEAT);
   assign w_accept    = w_stream & m_ready;

   // Beat count to bin index: straight through, or bit-reversed.
   generate
      if (BITREV) begin : g_rev
         fft_bitrev #(.N(LG)) u_bitrev (
            .i_idx (r_cnt),
            .o_idx (w_ord)
         );
      end else begin : g_nat
         assign w_ord = r_cnt;
      end
   endgenerate

   // Delayed copy of done for rising-edge detection; resetting to 0 makes a
   // done level already high at reset release count as a fresh frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_done_q <= 1'b0;
      else        r_done_q <= frame_done;
   end

   // State and beat counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state, counter advance, capture strobe and overrun detection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      overrun     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_new_frame) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (w_accept && w_final) begin
               // Frame done; a frame arriving right now chains with no gap.
               w_cnt_nxt = '0;
               if (w_new_frame) w_capture   = 1'b1;
               else             w_state_nxt = ST_IDLE;
            end else begin
               if (w_accept)    w_cnt_nxt = r_cnt + 1'b1;
               if (w_new_frame) overrun   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame buffer: all words loaded in parallel on capture, never reset.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         for (int i = 0; i < POINTS; i++) r_buf[i] <= frame_in[i];
      end
   end

   // Stream outputs depend only on registered state, count and buffer, so
   // they hold steady under backpressure and drop at once on reset.
   always_comb begin
      m_valid = w_stream;
      busy    = w_stream;
      m_last  = w_final;
      m_index = w_stream ? w_ord : '0;
      m_data  = w_stream ? r_buf[w_ord] : '0;
   end

endmodule

// File: tb/tb_fft_frame_unloader.sv
// Directed bench for fft_frame_unloader at POINTS=8: one natural-order and
// one bit-reversed instance driven from the same stimulus.
module tb_fft_frame_unloader;

   localparam int P  = 8;
   localparam int LG = 3;

   logic          clk;
   logic          rst_n;
   logic [31:0]   frame_in [P];
   logic          frame_done;
   logic          m_ready;

   logic [31:0]   d0_data,  d1_data;
   logic [LG-1:0] d0_index, d1_index;
   logic          d0_valid, d1_valid;
   logic          d0_last,  d1_last;
   logic          d0_busy,  d1_busy;
   logic          d0_ovr,   d1_ovr;

   int n_tests = 0;
   int n_fail  = 0;
   int rev_tab [P] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft_frame_unloader #(.POINTS(P), .DW(32), .BITREV(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_done(frame_done),
      .m_data(d0_data), .m_index(d0_index), .m_valid(d0_valid), .m_last(d0_last),
      .m_ready(m_ready), .busy(d0_busy), .overrun(d0_ovr)
   );

   fft_frame_unloader #(.POINTS(P), .DW(32), .BITREV(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_done(frame_done),
      .m_data(d1_data), .m_index(d1_index), .m_valid(d1_valid), .m_last(d1_last),
      .m_ready(m_ready), .busy(d1_busy), .overrun(d1_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic load_frame(input logic [31:0] base);
      for (int i = 0; i < P; i++) frame_in[i] = base + 32'(i);
   endtask

   task automatic gap();
      frame_done = 1'b0;
      m_ready    = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [38:0] got0, got1;
      rst_n = 1'b0; frame_done = 1'b0; m_ready = 1'b1;
      load_frame(32'hA000_0000);
      repeat (2) @(negedge clk);
      got0 = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
      got1 = {d1_valid, d1_last, d1_busy, d1_ovr, d1_index, d1_data};
      n_tests++;
      if (got0 !== 39'h0) begin n_fail++; $display("FAIL reset_dut0: got %h want 0", got0); end
      n_tests++;
      if (got1 !== 39'h0) begin n_fail++; $display("FAIL reset_dut1: got %h want 0", got1); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({d0_valid, d0_busy} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle: valid/busy %b want 00", {d0_valid, d0_busy});
      end
   endtask

   task automatic test_natural();
      logic [38:0] got, exp;
      load_frame(32'hA000_0000);
      @(posedge clk); #1 frame_done = 1'b1;
      for (int k = 0; k < P; k++) begin
         @(posedge clk); @(negedge clk);
         got = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
         exp = {1'b1, (k == P-1), 1'b1, 1'b0, 3'(k), 32'hA000_0000 + 32'(k)};
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL natural beat %0d: got %h want %h", k, got, exp); end
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({d0_valid, d0_busy, d0_last} !== 3'b000) begin
         n_fail++; $display("FAIL natural_end: valid/busy/last %b want 000", {d0_valid, d0_busy, d0_last});
      end
      gap();
   endtask

   task automatic test_bitrev();
      logic [38:0] got, exp;
      load_frame(32'hA000_0000);
      @(posedge clk); #1 frame_done = 1'b1;
      for (int k = 0; k < P; k++) begin
         @(posedge clk); @(negedge clk);
         got = {d1_valid, d1_last, d1_busy, d1_ovr, d1_index, d1_data};
         exp = {1'b1, (k == P-1), 1'b1, 1'b0, 3'(rev_tab[k]), 32'hA000_0000 + 32'(rev_tab[k])};
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL bitrev beat %0d: got %h want %h", k, got, exp); end
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({d1_valid, d1_busy} !== 2'b00) begin
         n_fail++; $display("FAIL bitrev_end: valid/busy %b want 00", {d1_valid, d1_busy});
      end
      gap();
   endtask

   task automatic test_backpressure();
      logic [38:0] got, exp;
      int b;
      load_frame(32'hA000_0000);
      @(posedge clk); #1 frame_done = 1'b1;
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1 m_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         b = (c <= 2) ? c : ((c <= 5) ? 2 : c - 3);
         got = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
         exp = {1'b1, (b == P-1), 1'b1, 1'b0, 3'(b), 32'hA000_0000 + 32'(b)};
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL backpressure cycle %0d: got %h want %h", c, got, exp); end
      end
      m_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (d0_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_end: valid %b want 0", d0_valid); end
      gap();
   endtask

   task automatic test_overrun();
      logic [38:0] got, exp;
      load_frame(32'hA000_0000);
      @(posedge clk); #1 frame_done = 1'b1;
      for (int c = 0; c < P; c++) begin
         @(posedge clk); #1;
         if (c == 3) frame_done = 1'b0;
         if (c == 5) frame_done = 1'b1;
         @(negedge clk);
         got = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
         exp = {1'b1, (c == P-1), 1'b1, (c == 5), 3'(c), 32'hA000_0000 + 32'(c)};
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL overrun cycle %0d: got %h want %h", c, got, exp); end
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk);
         n_tests++;
         if ({d0_valid, d0_ovr} !== 2'b00) begin
            n_fail++; $display("FAIL overrun_drop %0d: valid/ovr %b want 00", c, {d0_valid, d0_ovr});
         end
      end
      gap();
   endtask

   task automatic test_back_to_back();
      logic [38:0] got, exp;
      logic [31:0] d;
      int b;
      load_frame(32'hA000_0000);
      @(posedge clk); #1 frame_done = 1'b1;
      for (int c = 0; c < 2*P; c++) begin
         @(posedge clk); #1;
         if (c == 5) frame_done = 1'b0;
         if (c == 7) begin frame_done = 1'b1; load_frame(32'hB000_0000); end
         @(negedge clk);
         b = c % P;
         d = (c < P) ? 32'hA000_0000 + 32'(b) : 32'hB000_0000 + 32'(b);
         got = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
         exp = {1'b1, (b == P-1), 1'b1, 1'b0, 3'(b), d};
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL back_to_back cycle %0d: got %h want %h", c, got, exp); end
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (d0_valid !== 1'b0) begin n_fail++; $display("FAIL back_to_back_end: valid %b want 0", d0_valid); end
      gap();
   endtask

   task automatic test_reset_midstream();
      logic [38:0] got, exp;
      load_frame(32'hA000_0000);
      @(posedge clk); #1 frame_done = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); @(negedge clk);
         got = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
         exp = {1'b1, 1'b0, 1'b1, 1'b0, 3'(c), 32'hA000_0000 + 32'(c)};
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL midreset pre beat %0d: got %h want %h", c, got, exp); end
      end
      #2 rst_n = 1'b0;
      #1;
      got = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
      n_tests++;
      if (got !== 39'h0) begin n_fail++; $display("FAIL midreset_abort: got %h want 0", got); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < P; k++) begin
         @(posedge clk); @(negedge clk);
         got = {d0_valid, d0_last, d0_busy, d0_ovr, d0_index, d0_data};
         exp = {1'b1, (k == P-1), 1'b1, 1'b0, 3'(k), 32'hA000_0000 + 32'(k)};
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL midreset restart beat %0d: got %h want %h", k, got, exp); end
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (d0_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_end: valid %b want 0", d0_valid); end
      gap();
   endtask

   initial begin
      test_reset();
      test_natural();
      test_bitrev();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
